seg_scan_display: RTL and testbench

- Downstream consumer of the CPU core's three debug counters: fall_num, eggs and broken.
- Converts fall_num and eggs to decimal with an iterative shift-add-3 converter. Shows broken as hex.
- Time-multiplexes the result onto the board's 8-digit common-anode seven-segment display (active-low anodes and segments).
- Sits at board top, beside the CPU core, and is driven by the same board clock.

---
 rtl/seg_scan_display_pkg.sv | 69 ++++++
 rtl/bin2bcd_seq.sv | 47 ++++
 rtl/seg_scan_display.sv | 125 ++++++++++++
 tb/tb_seg_scan_display.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_display_pkg.sv
// Shared constants for the seven-segment scan display: segment codes,
// conversion FSM states, digit positions and the decimal field encoder.
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  localparam int unsigned NUM_DIGITS    = 8;
  localparam int unsigned DIG_BRK_LO    = 0;
  localparam int unsigned DIG_BRK_HI    = 1;
  localparam int unsigned DIG_EGG_ONES  = 2;
  localparam int unsigned DIG_EGG_TENS  = 3;
  localparam int unsigned DIG_EGG_HUND  = 4;
  localparam int unsigned DIG_FALL_ONES = 5;
  localparam int unsigned DIG_FALL_TENS = 6;
  localparam int unsigned DIG_FALL_HUND = 7;

  function automatic logic [7:0] seg_hex(input logic [3:0] nib);
    case (nib)
      4'h0: seg_hex = SEG_0;
      4'h1: seg_hex = SEG_1;
      4'h2: seg_hex = SEG_2;
      4'h3: seg_hex = SEG_3;
      4'h4: seg_hex = SEG_4;
      4'h5: seg_hex = SEG_5;
      4'h6: seg_hex = SEG_6;
      4'h7: seg_hex = SEG_7;
      4'h8: seg_hex = SEG_8;
      4'h9: seg_hex = SEG_9;
      4'hA: seg_hex = SEG_A;
      4'hB: seg_hex = SEG_B;
      4'hC: seg_hex = SEG_C;
      4'hD: seg_hex = SEG_D;
      4'hE: seg_hex = SEG_E;
      default: seg_hex = SEG_F;
    endcase
  endfunction

  // Returns {hundreds, tens, ones} segment codes; ones always shows.
  function automatic logic [23:0] dec3_seg(input logic [11:0] bcd, input logic blank_lz);
    logic [7:0] hund, tens, ones;
    hund = (blank_lz && bcd[11:8] == 4'h0) ? SEG_BLANK : seg_hex(bcd[11:8]);
    tens = (blank_lz && bcd[11:4] == 8'h00) ? SEG_BLANK : seg_hex(bcd[7:4]);
    ones = seg_hex(bcd[3:0]);
    dec3_seg = {hund, tens, ones};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// 8-bit sequential shift-add-3 binary to BCD converter; eight steps after a
// load leave the three-digit result on bcd_o.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [7:0]  bin_i,
  output logic [11:0] bcd_o
);

  logic [11:0] bcd_q, bcd_d, bcd_adj;
  logic [7:0]  bin_q, bin_d;
  logic [19:0] shifted;

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned n = 0; n < 3; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin_q} << 1;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    if (load_i) begin
      bcd_d = '0;
      bin_d = bin_i;
    end else if (step_i) begin
      bcd_d = shifted[19:8];
      bin_d = shifted[7:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bcd_q <= '0;
      bin_q <= '0;
    end else begin
      bcd_q <= bcd_d;
      bin_q <= bin_d;
    end
  end

  assign bcd_o = bcd_q;

endmodule

// File: rtl/seg_scan_display.sv
// Converts the CPU debug counters to decimal/hex and time-multiplexes them
// onto an 8-digit common-anode seven-segment display.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] fall_num,
  input  logic [7:0] eggs,
  input  logic [7:0] broken,
  output logic [7:0] seg,
  output logic [7:0] an,
  output logic       valid
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  state_e      state_q;
  logic [2:0]  bitcnt_q;
  logic [7:0]  broken_q;
  logic        valid_q;
  logic [7:0]  digit_q [NUM_DIGITS];
  logic [7:0]  digit_new [NUM_DIGITS];
  logic [11:0] fall_bcd, eggs_bcd;
  logic        conv_load, conv_step;

  assign conv_load = (state_q == S_LOAD);
  assign conv_step = (state_q == S_SHIFT);

  bin2bcd_seq u_fall_bcd (
    .clk_i (clk), .rst_i (rst), .load_i (conv_load), .step_i (conv_step),
    .bin_i (fall_num), .bcd_o (fall_bcd)
  );

  bin2bcd_seq u_eggs_bcd (
    .clk_i (clk), .rst_i (rst), .load_i (conv_load), .step_i (conv_step),
    .bin_i (eggs), .bcd_o (eggs_bcd)
  );

  // Eggs spans digits 4..2; the blanking rule alone keeps digit 4 dark below 100.
  always_comb begin
    {digit_new[DIG_FALL_HUND], digit_new[DIG_FALL_TENS], digit_new[DIG_FALL_ONES]} =
      dec3_seg(fall_bcd, BLANK_LZ);
    {digit_new[DIG_EGG_HUND], digit_new[DIG_EGG_TENS], digit_new[DIG_EGG_ONES]} =
      dec3_seg(eggs_bcd, BLANK_LZ);
    digit_new[DIG_BRK_HI] = seg_hex(broken_q[7:4]);
    digit_new[DIG_BRK_LO] = seg_hex(broken_q[3:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_LOAD;
      bitcnt_q <= '0;
      broken_q <= '0;
      valid_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) digit_q[i] <= SEG_BLANK;
    end else begin
      case (state_q)
        S_LOAD: begin
          broken_q <= broken;
          bitcnt_q <= 3'd7;
          state_q  <= S_SHIFT;
        end
        S_SHIFT: begin
          if (bitcnt_q == 3'd0) state_q <= S_COMMIT;
          else bitcnt_q <= bitcnt_q - 3'd1;
        end
        S_COMMIT: begin
          for (int unsigned i = 0; i < NUM_DIGITS; i++) digit_q[i] <= digit_new[i];
          valid_q <= 1'b1;
          state_q <= S_LOAD;
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic             lit_q, upd;
  logic [7:0]       an_q, seg_q;

  // First edge after reset lights digit 0 without advancing, so every digit holds SCAN_DIV cycles.
  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    upd   = 1'b0;
    if (!lit_q) begin
      upd = 1'b1;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 3'd1;
      upd   = 1'b1;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
      lit_q <= 1'b0;
      an_q  <= '1;
      seg_q <= SEG_BLANK;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      lit_q <= 1'b1;
      if (upd) begin
        an_q  <= ~(8'b1 << idx_d);
        seg_q <= digit_q[idx_d];
      end
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed self-checking bench for seg_scan_display (two instances:
// leading-zero blanking on and off, both scanning every 4 cycles).
module tb_seg_scan_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] fall_num = '0, eggs = '0, broken = '0;
  logic [7:0] seg_a, an_a, seg_b, an_b;
  logic       valid_a, valid_b;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  seg_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst(rst), .fall_num(fall_num), .eggs(eggs), .broken(broken),
    .seg(seg_a), .an(an_a), .valid(valid_a)
  );

  seg_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst(rst), .fall_num(fall_num), .eggs(eggs), .broken(broken),
    .seg(seg_b), .an(an_b), .valid(valid_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    fall_num = 8'd5; eggs = 8'd6; broken = 8'h77;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (an_a !== 8'hFF || seg_a !== 8'hFF || valid_a !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc%0d: an=%h seg=%h valid=%b expected an=ff seg=ff valid=0",
                 c, an_a, seg_a, valid_a);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) begin
        checks++;
        if (an_a !== 8'hFE || seg_a !== 8'hFF) begin
          failures++;
          $display("FAIL first_digit: an=%h seg=%h expected an=fe seg=ff", an_a, seg_a);
        end
      end
      if (k >= 9) begin
        checks++;
        if (valid_a !== (k == 10) || valid_b !== (k == 10)) begin
          failures++;
          $display("FAIL valid_rise edge%0d: valid_a=%b valid_b=%b expected %b",
                   k, valid_a, valid_b, (k == 10));
        end
      end
    end
  endtask

  task automatic test_scan_order();
    logic [7:0] exp_an;
    apply_reset();
    for (int k = 1; k <= 72; k++) begin
      step();
      exp_an = ~(8'b1 << (((k - 1) / 4) % 8));
      checks++;
      if (an_a !== exp_an || an_b !== exp_an) begin
        failures++;
        $display("FAIL scan_order edge%0d: an_a=%h an_b=%h expected %h", k, an_a, an_b, exp_an);
      end
      checks++;
      if ($countones(~an_a) != 1) begin
        failures++;
        $display("FAIL one_hot edge%0d: an_a=%h expected exactly one low bit", k, an_a);
      end
    end
  endtask

  task automatic test_conversion();
    logic [7:0]  vf [5] = '{8'd255, 8'd0, 8'd10, 8'd200, 8'd147};
    logic [7:0]  ve [5] = '{8'd7, 8'd100, 8'd99, 8'd0, 8'd68};
    logic [7:0]  vb [5] = '{8'h01, 8'hAF, 8'h5C, 8'h3B, 8'hDE};
    logic [63:0] ea [5] = '{64'hA4_92_92_FF_FF_F8_C0_F9, 64'hFF_FF_C0_F9_C0_C0_88_8E,
                            64'hFF_F9_C0_FF_90_90_92_C6, 64'hA4_C0_C0_FF_FF_C0_B0_83,
                            64'hF9_99_F8_FF_82_80_A1_86};
    logic [63:0] eb [5] = '{64'hA4_92_92_C0_C0_F8_C0_F9, 64'hC0_C0_C0_F9_C0_C0_88_8E,
                            64'hC0_F9_C0_C0_90_90_92_C6, 64'hA4_C0_C0_C0_C0_C0_B0_83,
                            64'hF9_99_F8_C0_82_80_A1_86};
    logic [7:0] got_a [8];
    logic [7:0] got_b [8];
    logic [63:0] cur_a, cur_b;
    for (int v = 0; v < 5; v++) begin
      fall_num = vf[v]; eggs = ve[v]; broken = vb[v];
      apply_reset();
      repeat (40) step();
      for (int d = 0; d < 8; d++) begin
        got_a[d] = 8'h00;
        got_b[d] = 8'h00;
      end
      for (int c = 0; c < 32; c++) begin
        step();
        for (int d = 0; d < 8; d++) begin
          if (an_a[d] == 1'b0) got_a[d] = seg_a;
          if (an_b[d] == 1'b0) got_b[d] = seg_b;
        end
      end
      cur_a = ea[v];
      cur_b = eb[v];
      for (int d = 0; d < 8; d++) begin
        checks++;
        if (got_a[d] !== cur_a[8*d +: 8]) begin
          failures++;
          $display("FAIL conv%0d_lz1 digit%0d: got %h expected %h", v, d, got_a[d], cur_a[8*d +: 8]);
        end
        checks++;
        if (got_b[d] !== cur_b[8*d +: 8]) begin
          failures++;
          $display("FAIL conv%0d_lz0 digit%0d: got %h expected %h", v, d, got_b[d], cur_b[8*d +: 8]);
        end
      end
    end
  endtask

  // Snapshots at edges 1,11,21,...; commits at 10,20,30,...; digit i lit at 4i+1 (+32m).
  task automatic test_snapshot();
    logic [7:0] exp_seg, exp_an;
    fall_num = 8'd12; eggs = 8'd0; broken = 8'h00;
    apply_reset();
    for (int k = 1; k <= 61; k++) begin
      step();
      if (k == 13) fall_num = 8'd99;
      if (k == 15) fall_num = 8'd200;
      exp_seg = 8'h00;
      exp_an  = 8'h00;
      case (k)
        21: begin exp_an = 8'hDF; exp_seg = 8'hA4; end
        25: begin exp_an = 8'hBF; exp_seg = 8'hF9; end
        29: begin exp_an = 8'h7F; exp_seg = 8'hFF; end
        53: begin exp_an = 8'hDF; exp_seg = 8'hC0; end
        57: begin exp_an = 8'hBF; exp_seg = 8'hC0; end
        61: begin exp_an = 8'h7F; exp_seg = 8'hA4; end
        default: ;
      endcase
      if (exp_an != 8'h00) begin
        checks++;
        if (an_a !== exp_an || seg_a !== exp_seg) begin
          failures++;
          $display("FAIL snapshot edge%0d: an=%h seg=%h expected an=%h seg=%h",
                   k, an_a, seg_a, exp_an, exp_seg);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    fall_num = 8'd33; eggs = 8'd44; broken = 8'h55;
    apply_reset();
    for (int k = 1; k <= 14; k++) step();
    checks++;
    if (valid_a !== 1'b1 || an_a === 8'hFF) begin
      failures++;
      $display("FAIL midop_pre: valid=%b an=%h expected valid=1 an!=ff", valid_a, an_a);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (an_a !== 8'hFF || seg_a !== 8'hFF || valid_a !== 1'b0) begin
      failures++;
      $display("FAIL midop_reset: an=%h seg=%h valid=%b expected an=ff seg=ff valid=0",
               an_a, seg_a, valid_a);
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) begin
        checks++;
        if (an_a !== 8'hFE || seg_a !== 8'hFF) begin
          failures++;
          $display("FAIL midop_restart: an=%h seg=%h expected an=fe seg=ff", an_a, seg_a);
        end
      end
      if (k == 9) begin
        checks++;
        if (valid_a !== 1'b0 || seg_a !== 8'hFF || an_a !== 8'hFB) begin
          failures++;
          $display("FAIL midop_blank: valid=%b seg=%h an=%h expected valid=0 seg=ff an=fb",
                   valid_a, seg_a, an_a);
        end
      end
      if (k == 10) begin
        checks++;
        if (valid_a !== 1'b1) begin
          failures++;
          $display("FAIL midop_valid: valid=%b expected 1", valid_a);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_conversion();
    test_snapshot();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
